// File: rtl/reg_writeback_if.sv
// reg_writeback_if: write-request handshakes from ALU/memory stages plus the register-file write port
interface reg_writeback_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  mem_wb_valid;
  logic                  mem_wb_ready;
  logic [ADDR_WIDTH-1:0] mem_wb_addr;
  logic [DATA_WIDTH-1:0] mem_wb_data;
  logic                  alu_wb_valid;
  logic                  alu_wb_ready;
  logic [ADDR_WIDTH-1:0] alu_wb_addr;
  logic [DATA_WIDTH-1:0] alu_wb_data;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  modport master (
    input  mem_wb_valid, mem_wb_addr, mem_wb_data,
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    output mem_wb_ready, alu_wb_ready,
    output rf_we, rf_waddr, rf_wdata
  );
  modport slave (
    output mem_wb_valid, mem_wb_addr, mem_wb_data,
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  mem_wb_ready, alu_wb_ready,
    input  rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: FIFO-buffered register-file write master; define WB_BYPASS_EN for the bypass lookup
module reg_writeback #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  reg_writeback_if.master          wb,
  output logic [$clog2(DEPTH):0]   pending,
  input  logic [ADDR_WIDTH-1:0]    byp_addr,
  output logic                     byp_hit,
  output logic [DATA_WIDTH-1:0]    byp_data
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [PW:0]           cnt;
  logic                  full, push, pop, discard;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;
  assign full            = cnt == (PW+1)'(DEPTH);
  assign wb.mem_wb_ready = !full;
  assign wb.alu_wb_ready = !full && !wb.mem_wb_valid;
  assign push_addr       = wb.mem_wb_valid ? wb.mem_wb_addr : wb.alu_wb_addr;
  assign push_data       = wb.mem_wb_valid ? wb.mem_wb_data : wb.alu_wb_data;
  assign discard         = ZERO_REG != 0 && push_addr == '0;
  assign push            = !full && (wb.mem_wb_valid || wb.alu_wb_valid) && !discard;
  assign pop             = cnt != '0;
  assign pending         = cnt;
  // entry storage needs no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end
  // pointers, occupancy and the registered register-file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      wb.rf_we    <= 1'b0;
      wb.rf_waddr <= '0;
      wb.rf_wdata <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head        <= head + 1'b1;
        wb.rf_waddr <= addr_q[head];
        wb.rf_wdata <= data_q[head];
      end
      wb.rf_we <= pop;
      cnt      <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
`ifdef WB_BYPASS_EN
  // scan oldest to newest so the newest match overrides; rf_* is older than any queued entry
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (wb.rf_we && wb.rf_waddr == byp_addr) begin
      byp_hit  = 1'b1;
      byp_data = wb.rf_wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < cnt && addr_q[head + PW'(i)] == byp_addr) begin
        byp_hit  = 1'b1;
        byp_data = data_q[head + PW'(i)];
      end
    end
    if (ZERO_REG != 0 && byp_addr == '0) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^byp_addr;
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: queue-model scoreboard for reg_writeback with directed and random stimulus
module tb_reg_writeback;
  localparam int DEPTH = 4;
  typedef struct { logic [2:0] a; logic [7:0] d; } ent_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pending;
  logic [2:0] byp_addr;
  logic       byp_hit;
  logic [7:0] byp_data;
  int         n_checks = 0;
  int         n_fail = 0;
  ent_t       mq[$];
  ent_t       exp_q[$];
  ent_t       mon_e;
  logic       m_we = 1'b0;
  logic [2:0] m_ra = '0;
  logic [7:0] m_rd = '0;
  reg_writeback_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();
  reg_writeback #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (bus.master),
    .pending  (pending),
    .byp_addr (byp_addr),
    .byp_hit  (byp_hit),
    .byp_data (byp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // scoreboard monitor: every rf write must be the oldest outstanding accepted write
  always @(posedge clk) begin
    #1;
    if (bus.rf_we) begin
      if (exp_q.size() == 0) chk("unexpected_rf_write", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rf_waddr", int'(bus.rf_waddr), int'(mon_e.a));
        chk("rf_wdata", int'(bus.rf_wdata), int'(mon_e.d));
      end
    end
  end
  task automatic step(input logic mv, input logic [2:0] ma, input logic [7:0] md,
                      input logic av, input logic [2:0] aa, input logic [7:0] ad,
                      input logic [2:0] ba);
    ent_t e;
    logic acc;
    logic hit;
    logic [7:0] bd;
    @(negedge clk);
    bus.mem_wb_valid = mv; bus.mem_wb_addr = ma; bus.mem_wb_data = md;
    bus.alu_wb_valid = av; bus.alu_wb_addr = aa; bus.alu_wb_data = ad;
    byp_addr = ba;
    #1;
    chk("mem_wb_ready", int'(bus.mem_wb_ready), int'(mq.size() < DEPTH));
    chk("alu_wb_ready", int'(bus.alu_wb_ready), int'(mq.size() < DEPTH && !mv));
    chk("pending", int'(pending), mq.size());
    chk("rf_we", int'(bus.rf_we), int'(m_we));
    hit = 1'b0;
    bd  = '0;
`ifdef WB_BYPASS_EN
    if (m_we && m_ra == ba) begin hit = 1'b1; bd = m_rd; end
    foreach (mq[i]) if (mq[i].a == ba) begin hit = 1'b1; bd = mq[i].d; end
    if (ba == 3'd0) begin hit = 1'b0; bd = '0; end
`endif
    chk("byp_hit", int'(byp_hit), int'(hit));
    chk("byp_data", int'(byp_data), int'(bd));
    acc = (mv || av) && mq.size() < DEPTH;
    e.a = mv ? ma : aa;
    e.d = mv ? md : ad;
    if (mq.size() > 0) begin
      ent_t h;
      h = mq.pop_front();
      m_we = 1'b1; m_ra = h.a; m_rd = h.d;
    end else m_we = 1'b0;
    if (acc && e.a != 3'd0) begin
      mq.push_back(e);
      exp_q.push_back(e);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 3'd4);
  endtask
  initial begin
    bus.mem_wb_valid = 1'b0; bus.mem_wb_addr = '0; bus.mem_wb_data = '0;
    bus.alu_wb_valid = 1'b0; bus.alu_wb_addr = '0; bus.alu_wb_data = '0;
    byp_addr = 3'd4;
    #2;
    chk("reset_pending", int'(pending), 0);
    chk("reset_rf_we", int'(bus.rf_we), 0);
    chk("reset_rf_waddr", int'(bus.rf_waddr), 0);
    chk("reset_rf_wdata", int'(bus.rf_wdata), 0);
    chk("reset_byp_hit", int'(byp_hit), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h5A, 3'd3);
    idle(3);
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 3'd1);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h22, 3'd2);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b1, 3'(i + 1), 8'(8'hA0 + i), 1'b0, 3'd0, 8'd0, 3'(i + 1));
    idle(3);
    step(1'b1, 3'd0, 8'h77, 1'b0, 3'd0, 8'h00, 3'd0);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h66, 3'd0);
    idle(3);
    step(1'b1, 3'd5, 8'h55, 1'b0, 3'd0, 8'h00, 3'd5);
    step(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 3'd6);
    @(negedge clk);
    chk("pre_reset_rf_we", int'(bus.rf_we), 1);
    chk("pre_reset_pending", int'(pending), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_rf_we", int'(bus.rf_we), 0);
    chk("async_reset_pending", int'(pending), 0);
    chk("async_reset_rf_waddr", int'(bus.rf_waddr), 0);
    mq.delete(); exp_q.delete();
    m_we = 1'b0; m_ra = '0; m_rd = '0;
    bus.mem_wb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    step(1'b1, 3'd4, 8'h01, 1'b0, 3'd0, 8'h00, 3'd4);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h02, 3'd4);
    idle(4);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 3'($urandom));
    idle(6);
    chk("all_writes_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
